// File: rtl/apb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_register_bank
// Description : APB slave holding NumRegs consecutive word-addressed
//               registers, each read-write (stored) or read-only (live
//               reg_in). Programmable wait states, one-cycle write strobes,
//               and PSLVERROR on unmapped or illegal accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_register_bank #(
  parameter int unsigned             BaseAddress  = 0,
  parameter int unsigned             NumRegs      = 4,
  parameter int unsigned             AddrWidth    = 16,
  parameter int unsigned             DataWidth    = 32,
  parameter int unsigned             WaitStates   = 0,
  parameter logic [63:0]             ReadOnlyMask = '0,
  parameter logic [DataWidth-1:0]    ResetValue   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [AddrWidth-1:0]           PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DataWidth-1:0]           PWDATA,
  output logic                           PREADY,
  output logic [DataWidth-1:0]           PRDATA,
  output logic                           PSLVERROR,
  input  logic [NumRegs*DataWidth-1:0]   reg_in,
  output logic [NumRegs*DataWidth-1:0]   reg_out,
  output logic [NumRegs-1:0]             wr_strobe
);

  localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  // Extra headroom so BaseAddress+NumRegs never wraps at AddrWidth.
  localparam int unsigned ExtW = AddrWidth + 8;
  localparam logic [ExtW-1:0] BaseExt  = ExtW'(BaseAddress);
  localparam logic [ExtW-1:0] EndExt   = BaseExt + ExtW'(NumRegs);
  localparam bit              ZeroWait = (WaitStates == 0);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   hit_q, hit_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   prdata_q, prdata_d;
  logic [NumRegs-1:0]     strobe_q, strobe_d;
  logic [DataWidth-1:0]   regs_q [NumRegs];

  logic                   w_setup;
  logic [ExtW-1:0]        w_addr_ext;
  logic                   w_hit_cur;
  logic [IdxW-1:0]        w_idx_cur;
  logic                   w_ready;
  logic                   w_err_q;
  logic                   w_wr_en;
  logic                   w_load_rd;
  logic                   w_rd_hit;
  logic                   w_rd_write;
  logic [IdxW-1:0]        w_rd_idx;
  logic [DataWidth-1:0]   w_rd_val;

  assign w_setup    = PSEL && !PENABLE;
  assign w_addr_ext = ExtW'(PADDR);
  assign w_hit_cur  = (w_addr_ext >= BaseExt) && (w_addr_ext < EndExt);
  assign w_idx_cur  = IdxW'(PADDR - AddrWidth'(BaseAddress));

  // PREADY and the error flag come from registered state only.
  assign w_ready = (state_q == ACCESS) && (cnt_q == '0);
  assign w_err_q = !hit_q || (write_q && ReadOnlyMask[idx_q]);
  assign w_wr_en = w_ready && PSEL && write_q && !w_err_q;

  // The edge that starts the PREADY cycle: straight from setup when there
  // are no wait states, otherwise the last counting edge of ACCESS.
  assign w_load_rd  = (state_q == IDLE   && w_setup && ZeroWait) ||
                      (state_q == ACCESS && PSEL    && cnt_q == 4'd1);
  assign w_rd_hit   = (state_q == IDLE) ? w_hit_cur : hit_q;
  assign w_rd_write = (state_q == IDLE) ? PWRITE    : write_q;
  assign w_rd_idx   = (state_q == IDLE) ? w_idx_cur : idx_q;

  // Next-state logic: setup capture, wait countdown, completion and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (w_setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WaitStates);
          idx_d   = w_idx_cur;
          hit_d   = w_hit_cur;
          write_d = PWRITE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-data selection and one-hot strobe generation.
  always_comb begin
    w_rd_val = '0;
    strobe_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (IdxW'(i) == w_rd_idx) begin
        w_rd_val = ReadOnlyMask[i] ? reg_in[i*DataWidth +: DataWidth] : regs_q[i];
      end
      strobe_d[i] = w_wr_en && (idx_q == IdxW'(i));
    end
    prdata_d = (w_load_rd && w_rd_hit && !w_rd_write) ? w_rd_val : '0;
  end

  // Control state and registered bus outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      write_q  <= 1'b0;
      prdata_q <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
      strobe_q <= strobe_d;
    end
  end

  // Register storage; read-only entries are never written.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= ResetValue;
    end else if (w_wr_en) begin
      for (int i = 0; i < NumRegs; i++) begin
        if (idx_q == IdxW'(i) && !ReadOnlyMask[i]) regs_q[i] <= PWDATA;
      end
    end
  end

  generate
    for (genvar g = 0; g < NumRegs; g++) begin : g_reg_out
      assign reg_out[g*DataWidth +: DataWidth] = ReadOnlyMask[g] ? '0 : regs_q[g];
    end
  endgenerate

  assign PREADY    = w_ready;
  assign PSLVERROR = w_ready && w_err_q;
  assign PRDATA    = prdata_q;
  assign wr_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_register_bank
// Description : Randomised and directed bench for apb_register_bank with two
//               instances (wait states / read-only mix, and a top-of-range
//               base address) checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_register_bank;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NR = 4;

  localparam int          A_BASE = 16;
  localparam int          A_WS   = 2;
  localparam logic [63:0] A_RO   = 64'b1000;
  localparam logic [31:0] A_RST  = 32'hA5A5_0000;
  localparam int          B_BASE = 16'hFFFE;
  localparam int          B_WS   = 0;
  localparam logic [63:0] B_RO   = 64'b0;
  localparam logic [31:0] B_RST  = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [AW-1:0]     paddr;
  logic [1:0]        psel;
  logic              penable, pwrite;
  logic [DW-1:0]     pwdata;

  logic              a_pready, a_pslverr, b_pready, b_pslverr;
  logic [DW-1:0]     a_prdata, b_prdata;
  logic [NR*DW-1:0]  a_reg_in, a_reg_out, b_reg_in, b_reg_out;
  logic [NR-1:0]     a_strobe, b_strobe;

  apb_register_bank #(
    .BaseAddress(A_BASE), .NumRegs(NR), .AddrWidth(AW), .DataWidth(DW),
    .WaitStates(A_WS), .ReadOnlyMask(A_RO), .ResetValue(A_RST)
  ) dut_a (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[0]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
    .PREADY(a_pready), .PRDATA(a_prdata), .PSLVERROR(a_pslverr),
    .reg_in(a_reg_in), .reg_out(a_reg_out), .wr_strobe(a_strobe)
  );

  apb_register_bank #(
    .BaseAddress(B_BASE), .NumRegs(NR), .AddrWidth(AW), .DataWidth(DW),
    .WaitStates(B_WS), .ReadOnlyMask(B_RO), .ResetValue(B_RST)
  ) dut_b (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[1]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
    .PREADY(b_pready), .PRDATA(b_prdata), .PSLVERROR(b_pslverr),
    .reg_in(b_reg_in), .reg_out(b_reg_out), .wr_strobe(b_strobe)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [2][NR];
  logic [NR-1:0] ro_m [2];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int base_of(int s);   return s ? B_BASE : A_BASE; endfunction
  function automatic int ws_of(int s);     return s ? B_WS : A_WS;     endfunction
  function automatic logic f_rdy(int s);   return s ? b_pready : a_pready;   endfunction
  function automatic logic f_err(int s);   return s ? b_pslverr : a_pslverr; endfunction
  function automatic logic [DW-1:0] f_prdata(int s);    return s ? b_prdata : a_prdata; endfunction
  function automatic logic [NR-1:0] f_strobe(int s);    return s ? b_strobe : a_strobe; endfunction
  function automatic logic [NR*DW-1:0] f_regout(int s); return s ? b_reg_out : a_reg_out; endfunction

  function automatic logic m_hit(int s, int addr);
    longint b = longint'(base_of(s));
    return (longint'(addr) >= b) && (longint'(addr) < b + NR);
  endfunction

  function automatic logic [NR*DW-1:0] m_reg_out(int s);
    logic [NR*DW-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = ro_m[s][i] ? '0 : mem[s][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mem[0][i] = A_RST;
      mem[1][i] = B_RST;
    end
  endtask

  // One complete transfer; starts in the setup cycle, returns in the cycle
  // after PREADY with the bus idle (a following call is back-to-back).
  task automatic xfer(input int s, input bit wr, input int addr, input logic [DW-1:0] data);
    logic          hit, err;
    int            idx, waited;
    logic [DW-1:0] exp_rd;
    hit = m_hit(s, addr);
    idx = addr - base_of(s);
    paddr = AW'(addr); pwrite = wr; pwdata = data; penable = 1'b0;
    psel = s ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    penable = 1'b1;
    check_value("strobe_t1", f_strobe(s), '0);
    waited = 0;
    while (!f_rdy(s) && waited < 20) begin
      check_value("prdata_wait", f_prdata(s), '0);
      @(posedge clk); #1;
      waited++;
    end
    check_value("wait_states", waited, ws_of(s));
    err = !hit;
    if (hit) err = wr && ro_m[s][idx];
    exp_rd = '0;
    if (hit && !wr) exp_rd = ro_m[s][idx] ? (s ? b_reg_in[idx*DW +: DW] : a_reg_in[idx*DW +: DW])
                                          : mem[s][idx];
    check_value("pslverror", f_err(s), err);
    check_value("prdata", f_prdata(s), exp_rd);
    if (wr && !err) mem[s][idx] = data;
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    check_value("wr_strobe", f_strobe(s), (wr && !err) ? (NR'(1) << idx) : '0);
    check_value("reg_out", f_regout(s), m_reg_out(s));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Drives setup then access for a write to A and stops at the T2 cycle.
  task automatic start_to_t2(input int addr, input logic [DW-1:0] data);
    paddr = AW'(addr); pwrite = 1'b1; pwdata = data; psel = 2'b01; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    ro_m[0] = A_RO[NR-1:0];
    ro_m[1] = B_RO[NR-1:0];
    model_reset();
    rst_n = 1'b0; paddr = '0; psel = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    a_reg_in = '0; b_reg_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_value("rst_pready_a", a_pready, 1'b0);
    check_value("rst_pslverr_a", a_pslverr, 1'b0);
    check_value("rst_prdata_a", a_prdata, '0);
    check_value("rst_strobe_a", a_strobe, '0);
    check_value("rst_regout_a", a_reg_out, m_reg_out(0));
    check_value("rst_regout_b", b_reg_out, m_reg_out(1));
    check_value("rst_pready_b", b_pready, 1'b0);

    // Directed: basic write/read, reset value, read-only, errors
    idle_cycle();
    xfer(0, 1, 18, 32'hDEADBEEF);
    idle_cycle();
    xfer(0, 0, 18, '0);
    xfer(0, 0, 16, '0);
    a_reg_in[3*DW +: DW] = 32'h0000_00FF;
    xfer(0, 0, 19, '0);
    xfer(0, 1, 19, 32'h1234);
    xfer(0, 0, 20, '0);
    xfer(0, 0, 15, '0);
    // Top-of-range base: no wrap to address 0
    xfer(1, 1, 16'hFFFF, 32'hCAFE_F00D);
    xfer(1, 0, 16'hFFFF, '0);
    xfer(1, 0, 0, '0);
    xfer(1, 1, 1, 32'h7);
    // Back-to-back writes
    xfer(1, 1, 16'hFFFE, 32'h1);
    xfer(1, 1, 16'hFFFF, 32'h2);
    xfer(0, 1, 16, 32'h1);
    xfer(0, 1, 17, 32'h2);
    idle_cycle();

    // Abort: PSEL dropped at T2
    start_to_t2(17, 32'h55);
    psel = 2'b00; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_value("abort_pready", a_pready, 1'b0);
      check_value("abort_strobe", a_strobe, '0);
      idle_cycle();
    end
    check_value("abort_regout", a_reg_out, m_reg_out(0));

    // Protocol violation: access phase without setup
    paddr = AW'(16); pwrite = 1'b1; pwdata = 32'hBAD; psel = 2'b01; penable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle_cycle();
      check_value("noset_pready", a_pready, 1'b0);
    end
    psel = 2'b00; penable = 1'b0;
    idle_cycle();
    check_value("noset_strobe", a_strobe, '0);
    check_value("noset_regout", a_reg_out, m_reg_out(0));

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      int s, addr, r;
      s = int'($urandom_range(0, 1));
      a_reg_in = {$urandom, $urandom, $urandom, $urandom};
      b_reg_in = {$urandom, $urandom, $urandom, $urandom};
      if (s == 0) addr = 14 + int'($urandom_range(0, 7));
      else begin
        r = int'($urandom_range(0, 6));
        addr = (r < 5) ? (16'hFFFB + r) : (r - 5);
      end
      xfer(s, 1'($urandom_range(0, 1)), addr, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Reset pulsed in the middle of a write
    xfer(0, 1, 17, 32'h1111_2222);
    start_to_t2(17, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_value("mrst_pready", a_pready, 1'b0);
    check_value("mrst_pslverr", a_pslverr, 1'b0);
    check_value("mrst_prdata", a_prdata, '0);
    check_value("mrst_strobe", a_strobe, '0);
    check_value("mrst_regout_a", a_reg_out, m_reg_out(0));
    check_value("mrst_regout_b", b_reg_out, m_reg_out(1));
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      idle_cycle();
      check_value("post_rst_pready", a_pready, 1'b0);
      check_value("post_rst_strobe", a_strobe, '0);
    end
    xfer(0, 0, 17, '0);
    xfer(1, 0, 16'hFFFF, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_register_bank.md
# apb_register_bank

Parametrised APB slave holding `NumRegs` consecutive registers, each selectable as read-write (stored, drives `reg_out`) or read-only (returns live `reg_in`). It has a programmable wait-state count, single-cycle write strobes, and `PSLVERROR` on unmapped or illegal accesses. It replaces hand-instantiated single-register slaves behind the APB multiplexer and occupies one address range [`BaseAddress`, `BaseAddress+NumRegs-1`].

## Interface
- `BaseAddress`, 0: address of register 0; register i sits at `BaseAddress+i` (word-index addressing, no byte offset).
- `NumRegs`, 4: number of registers, 1..64.
- `AddrWidth`, 16: `PADDR` width.
- `DataWidth`, 32: register and data width.
- `WaitStates`, 0: extra access-phase cycles before `PREADY`, 0..15.
- `ReadOnlyMask`, 0: bit i set = register i read-only.
- `ResetValue`, 0: reset value of every read-write register.

Ports:
- `PCLK` in 1: the only clock.
- `PRESETn` in 1: asynchronous, active-low reset.
- `PADDR` in `AddrWidth`: address.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write.
- `PWDATA` in `DataWidth`: write data.
- `PREADY` out 1: transfer completes this cycle.
- `PRDATA` out `DataWidth`: read data, valid while `PREADY`=1 on reads.
- `PSLVERROR` out 1: error response, valid while `PREADY`=1.
- `reg_in` in `NumRegs*DataWidth`: live values for read-only registers; slice i = register i.
- `reg_out` out `NumRegs*DataWidth`: stored values of read-write registers; slices of read-only registers are 0.
- `wr_strobe` out `NumRegs`: one-cycle pulse when register i has just been written.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: on `PSEL`=1 and `PENABLE`=0 (setup):
  - latch index = `PADDR-BaseAddress`;
  - latch `hit` = address in range;
  - latch `PWRITE`;
  - load the wait counter with `WaitStates`;
  - go to ACCESS.
- ACCESS with `PSEL`=1:
  - `PREADY` = (counter==0), decoded from registered state only;
  - counter decrements each cycle while nonzero.
- The edge ending the `PREADY` cycle completes the transfer and returns the FSM to IDLE.
- Write completing with `hit` and register read-write:
  - register updates from `PWDATA` at that edge;
  - `wr_strobe[i]`=1 for the following cycle only.
- Read completing with `hit`:
  - `PRDATA` is loaded on the edge that starts the `PREADY` cycle;
  - source is the stored value for read-write registers, `reg_in` sampled at that edge for read-only registers;
  - `PRDATA` is 0 in every other cycle.
- Error: `!hit`, or a write to a read-only register:
  - `PSLVERROR`=1 during the `PREADY` cycle;
  - no register or strobe change;
  - `PRDATA`=0.
- Abort: `PSEL` falls while in ACCESS → IDLE next edge, no write, no strobe, no error.
- Protocol violation: `PENABLE`=1 seen in IDLE (no setup) → ignored, stays IDLE, `PREADY`=0.
- Arithmetic:
  - range check is `PADDR>=BaseAddress && PADDR<BaseAddress+NumRegs`, evaluated at full `AddrWidth`, no wrap;
  - index is truncated to $clog2(`NumRegs`) bits, minimum 1.

## Timing
- Reset (async assert, sync release):
  - FSM IDLE, counter 0;
  - `PREADY`=0, `PRDATA`=0, `PSLVERROR`=0;
  - `wr_strobe`=0;
  - read-write registers = `ResetValue`.
- Reset mid-transfer: transfer is discarded; no write occurs even if `PREADY` was high in that cycle.
- Latency: setup at cycle T0 → `PREADY`=1 at cycle T1+`WaitStates`, for exactly one cycle per transfer.
- Write visible on `reg_out` one cycle after the `PREADY` cycle, aligned with `wr_strobe`.
- Back-to-back: a new setup is accepted in the cycle right after the `PREADY` cycle. Throughput is one transfer per 2+`WaitStates` cycles.
- Outputs never depend combinationally on bus inputs.

## Test plan
- NumRegs=4, BaseAddress=16, WaitStates=0: write 0xDEADBEEF to 18 → `PREADY` at T1, `PSLVERROR`=0; next cycle `reg_out[2]`=0xDEADBEEF, `wr_strobe`=0b0100 for one cycle; read 18 → `PRDATA`=0xDEADBEEF.
- WaitStates=3: read 16 → `PREADY` low T1..T3, high T4 only; `PRDATA`=`ResetValue` (0x0) at T4.
- ReadOnlyMask=0b1000, `reg_in[3]`=0x000000FF: read 19 → 0xFF. Write 0x1234 to 19 → `PSLVERROR`=1, `reg_out[3]`=0, no strobe.
- Read 20 and read 15 (out of range) → `PSLVERROR`=1, `PRDATA`=0; also `PADDR`=0xFFFF with BaseAddress=0xFFFE, NumRegs=4 → 0xFFFF hits register 1, no wrap to 0.
- WaitStates=2: write 0x55 to 17, drop `PSEL` at T2 → no `PREADY`, `reg_out[1]` unchanged, no strobe. Same sequence with `PRESETn` pulsed low at T2 → all outputs 0, registers = `ResetValue`.
- Back-to-back writes 0x1 to 16 then 0x2 to 17 with setups at T0 and T2 → both `PREADY` (T1, T3), strobes at T2 and T4.
